// File: rtl/peripheral_register_arbiter_pkg.sv
// Shared types for the peripheral register arbiter: FSM states, latched
// command layout and global limits.
package peripheral_arbiter_pkg;

    localparam int ARB_MAX_REQUESTERS = 8;
    localparam int ARB_GRANT_WIDTH    = $clog2(ARB_MAX_REQUESTERS);
    localparam int ARB_ADDR_WIDTH     = 2;
    localparam int ARB_DATA_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // Grant field is sized for the largest arbiter so one struct serves every
    // REQUESTERS setting; address and data follow the default map geometry.
    typedef struct packed {
        logic [ARB_GRANT_WIDTH-1:0] grant;
        logic                       write;
        logic [ARB_ADDR_WIDTH-1:0]  addr;
        logic [ARB_DATA_WIDTH-1:0]  wdata;
    } arb_cmd_t;

endpackage

// File: rtl/peripheral_register_arbiter_if.sv
// Requester command/response bus plus register-map adapter port.
interface peripheral_register_arbiter_if #(
    parameter int REQUESTERS = 2,
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 32
);
    localparam int REGS = 1 << ADDR_WIDTH;

    logic [REQUESTERS-1:0]                 req_valid;
    logic [REQUESTERS-1:0]                 req_write;
    logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [REQUESTERS-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [REQUESTERS-1:0]                 req_ready;
    logic [REQUESTERS-1:0]                 rsp_valid;
    logic [DATA_WIDTH-1:0]                 rsp_rdata;
    logic                                  busy;
    logic [REGS-1:0]                       reg_write_en;
    logic [DATA_WIDTH-1:0]                 reg_data_in;
    logic [REGS-1:0][DATA_WIDTH-1:0]       reg_data_out;

    // Arbiter side
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, reg_data_out,
        output req_ready, rsp_valid, rsp_rdata, busy, reg_write_en, reg_data_in
    );

    // Requesters and register map side
    modport master (
        output req_valid, req_write, req_addr, req_wdata, reg_data_out,
        input  req_ready, rsp_valid, rsp_rdata, busy, reg_write_en, reg_data_in
    );

endinterface

// File: rtl/peripheral_register_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after
// last_grant+1, wrapping modulo REQUESTERS.
module peripheral_rr_picker #(
    parameter int REQUESTERS = 2,
    parameter int IDX_W      = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] req,
    input  logic [IDX_W-1:0]      last_grant,
    output logic [REQUESTERS-1:0] grant_onehot,
    output logic [IDX_W-1:0]      grant_idx
);

    int         cand_s;
    logic [IDX_W-1:0] cand_idx_s;
    logic       found_s;

    // Rotating priority search; the first hit wins and later hits are ignored
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found_s      = 1'b0;
        cand_s       = 0;
        cand_idx_s   = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            cand_s = int'(last_grant) + 1 + i;
            if (cand_s >= REQUESTERS) begin
                cand_s = cand_s - REQUESTERS;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = IDX_W'(cand_s);
            if (!found_s && req[cand_idx_s]) begin
                found_s                  = 1'b1;
                grant_idx                = cand_idx_s;
                grant_onehot[cand_idx_s] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/peripheral_register_arbiter.sv
// Round-robin arbiter serialising requester accesses onto the peripheral
// register adapter: handshake in IDLE, register access in ACCESS, response
// pulse in RESP.
module peripheral_register_arbiter
    import peripheral_arbiter_pkg::*;
#(
    parameter int REQUESTERS = 2,
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH = ARB_DATA_WIDTH
) (
    input  logic clk,
    input  logic reset,
    peripheral_register_arbiter_if.slave bus
);

    localparam int REGS  = 1 << ADDR_WIDTH;
    localparam int IDX_W = $clog2(REQUESTERS);

    arb_state_e             state_r;
    arb_state_e             state_next_s;
    logic [IDX_W-1:0]       last_grant_r;
    logic [IDX_W-1:0]       win_idx_s;
    logic [REQUESTERS-1:0]  win_onehot_s;
    logic [REQUESTERS-1:0]  req_ready_s;
    logic                   take_s;
    arb_cmd_t               cmd_r;
    logic [REGS-1:0]        reg_write_en_s;
    logic [DATA_WIDTH-1:0]  reg_data_in_s;
    logic [REQUESTERS-1:0]  rsp_valid_r;
    logic [DATA_WIDTH-1:0]  rsp_rdata_r;

    peripheral_rr_picker #(
        .REQUESTERS (REQUESTERS),
        .IDX_W      (IDX_W)
    ) u_picker (
        .req          (bus.req_valid),
        .last_grant   (last_grant_r),
        .grant_onehot (win_onehot_s),
        .grant_idx    (win_idx_s)
    );

    // Next-state and adapter drive; ready only ever leaves IDLE
    always_comb begin
        state_next_s   = state_r;
        req_ready_s    = '0;
        take_s         = 1'b0;
        reg_write_en_s = '0;
        reg_data_in_s  = '0;
        case (state_r)
            IDLE: begin
                req_ready_s = win_onehot_s;
                if (|win_onehot_s) begin
                    take_s       = 1'b1;
                    state_next_s = ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                if (cmd_r.write) begin
                    reg_write_en_s = {{(REGS-1){1'b0}}, 1'b1} << cmd_r.addr;
                    reg_data_in_s  = cmd_r.wdata;
                end else begin
                    reg_write_en_s = '0;
                    reg_data_in_s  = '0;
                end
                state_next_s = RESP;
            end
            RESP: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Command latch and round-robin pointer, updated on the accepted handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= IDX_W'(REQUESTERS - 1);
            cmd_r        <= '0;
        end else if (take_s) begin
            last_grant_r <= win_idx_s;
            cmd_r.grant  <= ARB_GRANT_WIDTH'(win_idx_s);
            cmd_r.write  <= bus.req_write[win_idx_s];
            cmd_r.addr   <= bus.req_addr[win_idx_s];
            cmd_r.wdata  <= bus.req_wdata[win_idx_s];
        end
    end

    // Response register: read data captured at the end of ACCESS, pulsed in RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_r <= '0;
            rsp_rdata_r <= '0;
        end else if (state_r == ACCESS) begin
            rsp_valid_r <= {{(REQUESTERS-1){1'b0}}, 1'b1} << cmd_r.grant;
            rsp_rdata_r <= cmd_r.write ? '0 : bus.reg_data_out[cmd_r.addr];
        end else begin
            rsp_valid_r <= '0;
            rsp_rdata_r <= '0;
        end
    end

    assign bus.req_ready    = req_ready_s;
    assign bus.rsp_valid    = rsp_valid_r;
    assign bus.rsp_rdata    = rsp_rdata_r;
    assign bus.busy         = (state_r != IDLE);
    assign bus.reg_write_en = reg_write_en_s;
    assign bus.reg_data_in  = reg_data_in_s;

endmodule

// File: doc/peripheral_register_arbiter.md
# peripheral_register_arbiter

Round-robin arbiter that shares the peripheral's register bus adapter port (one-hot write enables, common write data, per-address read data array) between several requesters, such as a host bus bridge and an on-chip sequencer. Each requester gets a valid/ready command handshake and a one-cycle response pulse. The block sits between the requesters and the peripheral register map and serialises all accesses, one transaction at a time.

## Interface
- REQUESTERS, default 2: number of requester ports, from 2 to 8.
- ADDR_WIDTH, default 2: register address width. REGS = 2**ADDR_WIDTH.
- DATA_WIDTH, default 32: register data width.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  [REQUESTERS]  command valid, one bit per requester.
- req_write  in  [REQUESTERS]  1 = write, 0 = read.
- req_addr  in  [REQUESTERS][ADDR_WIDTH]  target register address.
- req_wdata  in  [REQUESTERS][DATA_WIDTH]  write data.
- req_ready  out  [REQUESTERS]  command accepted, one-hot or zero.
- rsp_valid  out  [REQUESTERS]  response pulse, one-hot or zero.
- rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters and valid with rsp_valid.
- busy  out  1  high while a transaction is in flight.
- reg_write_en  out  [REGS]  one-hot register write enable, driven to the adapter.
- reg_data_in  out  DATA_WIDTH  write data, driven to the adapter.
- reg_data_out  in  [REGS][DATA_WIDTH]  read data from the adapter, one entry per address.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - The arbiter picks a winner among the asserted req_valid bits. Search starts at last_grant+1 modulo REQUESTERS.
  - It raises req_ready[winner] combinationally in the same cycle.
  - On valid&ready it latches grant index, write flag, address and wdata, updates last_grant to the winner and moves to ACCESS.
  - With no valid requests it stays in IDLE.
- ACCESS:
  - Write: reg_write_en[addr] = 1 and reg_data_in = latched wdata. Captured read data = 0.
  - Read: reg_write_en = 0 and reg_data_out[addr] is captured.
  - Next state is RESP.
- RESP: rsp_valid[grant] = 1 and rsp_rdata = captured data. Next state is IDLE.
- req_ready is never asserted outside IDLE.
- Requesters hold valid and their fields stable until ready. Dropping valid before ready is legal and simply withdraws the request.
- Every address decodes. Unmapped slots are the map's concern (reads return 0, writes are ignored there).
- Only the winner is acknowledged. Losers keep valid asserted and compete again in the next IDLE.
- reg_data_in is driven only in ACCESS on writes and is 0 otherwise.
- busy = (state != IDLE).

## Timing
- Handshake in cycle T. reg_write_en or read capture in T+1. rsp_valid in T+2. IDLE again in T+3. Sustained throughput is one transaction per 3 cycles.
- Read data reflects register contents at T+1. A write by another requester cannot interleave with it.
- Values after reset:
  - state = IDLE and last_grant = REQUESTERS-1, so requester 0 wins first.
  - All outputs except req_ready read 0: rsp_valid, rsp_rdata, reg_write_en, reg_data_in and busy.
  - req_ready stays combinational: it may rise in the first IDLE cycle after reset for any asserted req_valid.
- Reset asserted in ACCESS or RESP:
  - The next cycle is IDLE.
  - No write pulse is issued after the reset edge and no rsp_valid is generated.
  - The in-flight transaction is lost, and the requester must reissue it.
- Simultaneous requests in the same cycle are resolved purely by the round-robin pointer. No requester waits more than REQUESTERS-1 transactions.
- A single requester issuing back-to-back commands gets one every 3 cycles. Its own grant does not lock out others.

## Structure
- Package peripheral_arbiter_pkg holds:
  - the state enum {IDLE, ACCESS, RESP};
  - the command struct {grant index, write, addr, wdata}, parameterised by localparams matching the defaults;
  - the ARB_MAX_REQUESTERS constant (8).
- Sub-module peripheral_rr_picker is combinational:
  - inputs: request vector and last_grant;
  - outputs: one-hot grant and its index;
  - it is instantiated once.
- The FSM, command latch and response register live in the top module.

## Test plan
- Reset with all inputs at zero: every output is 0 and busy = 0 for 5 cycles. Then requester 0 writes address 1 with data 0x5. Check reg_write_en = 0b0010 and reg_data_in = 0x5 at T+1, and rsp_valid = 0b01 with rsp_rdata = 0 at T+2.
- Requester 1 reads address 0 while the bench drives reg_data_out[0] = 0x0000_03E7. Check rsp_valid = 0b10 and rsp_rdata = 0x3E7 at T+2, with reg_write_en = 0 throughout.
- Both requesters hold valid for 6 transactions. Check grants alternate 0,1,0,1,0,1 and that the spacing between req_ready pulses is exactly 3 cycles.
- Read of address 3 while the bench drives reg_data_out[3] = 0: check rsp_rdata = 0. Write to address 3: check reg_write_en = 0b1000.
- Reset asserted during ACCESS of a write to address 0: check reg_write_en stays 0 in all later cycles, no rsp_valid appears, and state is IDLE on the next cycle.
- REQUESTERS = 3 with all requesters valid from reset: check the grant order is 0,1,2,0.
